alarm_clock_ctrl: RTL and testbench



---
 rtl/alarm_clock_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/alarm_clock_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarm_clock_pkg                                                          |
// | Shared types and limits for the alarm clock controller.                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package alarm_clock_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_CLK_H = 3'd1,
        ST_CLK_M = 3'd2,
        ST_ALM_H = 3'd3,
        ST_ALM_M = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // Two-digit BCD encoding of a small integer (0..99).
    function automatic logic [7:0] to_bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_debounce                                                             |
// | 2-FF synchronizer, stability filter and rising-edge one-cycle pulse.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = level_q & ~level_prev_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= i_btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign o_press = press_q;

endmodule
`default_nettype wire

// File: rtl/alarm_clock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alarm_clock_ctrl                                                         |
// | BCD 24h clock with set-mode FSM, alarm register and timed alarm output.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alarm_clock_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int ALARM_SECONDS   = 60
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_set_clock,
    input  logic btn_set_alarm,
    output bcd_t display_h1,
    output bcd_t display_h0,
    output bcd_t display_m1,
    output bcd_t display_m0,
    output bcd_t display_s1,
    output bcd_t display_s0,
    output logic alarm
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int AW = $clog2(ALARM_SECONDS + 1);

    localparam logic [7:0] C_HOUR_MAX = to_bcd2(HOUR_MAX);
    localparam logic [7:0] C_MIN_MAX  = to_bcd2(MIN_MAX);
    localparam logic [7:0] C_SEC_MAX  = to_bcd2(SEC_MAX);

    logic w_press_up, w_press_dn, w_press_sc, w_press_sa;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk_clk), .rst_n(reset_reset_n), .i_btn(btn_up),        .o_press(w_press_up));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk(clk_clk), .rst_n(reset_reset_n), .i_btn(btn_down),      .o_press(w_press_dn));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sc (
        .clk(clk_clk), .rst_n(reset_reset_n), .i_btn(btn_set_clock), .o_press(w_press_sc));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sa (
        .clk(clk_clk), .rst_n(reset_reset_n), .i_btn(btn_set_alarm), .o_press(w_press_sa));

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == vmax)              r = 8'h00;
        else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
        else                        r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == 8'h00)             r = vmax;
        else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
        else                        r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_edit(input logic [7:0] v, input logic [7:0] vmax,
                                            input logic up, input logic dn);
        logic [7:0] r;
        r = v;
        if (up)      r = bcd_inc(v, vmax);
        else if (dn) r = bcd_dec(v, vmax);
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [7:0]      alm_h_q, alm_h_d, alm_m_q, alm_m_d;
    logic            armed_q, armed_d;
    logic            alarm_q, alarm_d;
    logic [AW-1:0]   alm_cnt_q, alm_cnt_d;
    logic [23:0]     disp_q, disp_d;

    logic w_tick_en, w_tick, w_any_press, w_up_only, w_dn_only, w_dismiss;

    assign w_tick_en   = (state_q == ST_RUN) || (state_q == ST_ALM_H) || (state_q == ST_ALM_M);
    assign w_tick      = w_tick_en && (presc_q == PW'(CLK_HZ - 1));
    assign w_any_press = w_press_up | w_press_dn | w_press_sc | w_press_sa;
    assign w_up_only   = w_press_up & ~w_press_dn;
    assign w_dn_only   = w_press_dn & ~w_press_up;
    assign w_dismiss   = (state_q == ST_RUN) && alarm_q && w_any_press;

    always_comb begin
        state_d   = state_q;
        presc_d   = w_tick_en ? (w_tick ? '0 : presc_q + PW'(1)) : '0;
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        alm_h_d   = alm_h_q;
        alm_m_d   = alm_m_q;
        armed_d   = armed_q;
        alarm_d   = alarm_q;
        alm_cnt_d = alm_cnt_q;

        if (w_tick) begin
            sec_d = bcd_inc(sec_q, C_SEC_MAX);
            if (sec_q == C_SEC_MAX) begin
                min_d = bcd_inc(min_q, C_MIN_MAX);
                if (min_q == C_MIN_MAX) begin
                    hour_d = bcd_inc(hour_q, C_HOUR_MAX);
                end
            end
        end

        case (state_q)
            ST_RUN: begin
                // A press that silences the alarm does nothing else.
                if (!w_dismiss) begin
                    if (w_press_sc)      state_d = ST_CLK_H;
                    else if (w_press_sa) state_d = ST_ALM_H;
                end
            end
            ST_CLK_H: begin
                hour_d = bcd_edit(hour_q, C_HOUR_MAX, w_up_only, w_dn_only);
                if (w_press_sc) state_d = ST_CLK_M;
            end
            ST_CLK_M: begin
                min_d = bcd_edit(min_q, C_MIN_MAX, w_up_only, w_dn_only);
                if (w_press_sc) begin
                    state_d = ST_RUN;
                    sec_d   = 8'h00;
                end
            end
            ST_ALM_H: begin
                alm_h_d = bcd_edit(alm_h_q, C_HOUR_MAX, w_up_only, w_dn_only);
                if (w_press_sa) state_d = ST_ALM_M;
            end
            ST_ALM_M: begin
                alm_m_d = bcd_edit(alm_m_q, C_MIN_MAX, w_up_only, w_dn_only);
                if (w_press_sa) begin
                    state_d = ST_RUN;
                    armed_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (alarm_q && w_tick) begin
            if (alm_cnt_q <= AW'(1)) begin
                alarm_d   = 1'b0;
                alm_cnt_d = '0;
            end else begin
                alm_cnt_d = alm_cnt_q - AW'(1);
            end
        end
        if (w_dismiss) begin
            alarm_d   = 1'b0;
            alm_cnt_d = '0;
        end
        // Trigger is evaluated last so it overrides a same-cycle dismiss.
        if ((state_q == ST_RUN) && armed_q && w_tick &&
            (hour_d == alm_h_q) && (min_d == alm_m_q) && (sec_d == 8'h00)) begin
            alarm_d   = 1'b1;
            alm_cnt_d = AW'(ALARM_SECONDS);
        end

        if ((state_d == ST_ALM_H) || (state_d == ST_ALM_M)) disp_d = {alm_h_d, alm_m_d, 8'h00};
        else                                                disp_d = {hour_d, min_d, sec_d};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= ST_RUN;
            presc_q   <= '0;
            hour_q    <= 8'h00;
            min_q     <= 8'h00;
            sec_q     <= 8'h00;
            alm_h_q   <= 8'h00;
            alm_m_q   <= 8'h00;
            armed_q   <= 1'b0;
            alarm_q   <= 1'b0;
            alm_cnt_q <= '0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            alm_h_q   <= alm_h_d;
            alm_m_q   <= alm_m_d;
            armed_q   <= armed_d;
            alarm_q   <= alarm_d;
            alm_cnt_q <= alm_cnt_d;
            disp_q    <= disp_d;
        end
    end

    assign {display_h1, display_h0, display_m1, display_m0, display_s1, display_s0} = disp_q;
    assign alarm = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alarm_clock_ctrl                                                      |
// | Directed self-checking bench for alarm_clock_ctrl.                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alarm_clock_ctrl;
    import alarm_clock_pkg::*;

    localparam logic [3:0] B_UP = 4'b0001;
    localparam logic [3:0] B_DN = 4'b0010;
    localparam logic [3:0] B_SC = 4'b0100;
    localparam logic [3:0] B_SA = 4'b1000;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    bcd_t       h1, h0, m1, m0, s1, s0;
    logic       alarm;
    int         n_checks;
    int         n_pass;
    int         pulse_cnt;
    int         pulse_idx;

    alarm_clock_ctrl #(
        .CLK_HZ(10),
        .DEBOUNCE_CYCLES(2),
        .ALARM_SECONDS(3)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .btn_up(btn[0]),
        .btn_down(btn[1]),
        .btn_set_clock(btn[2]),
        .btn_set_alarm(btn[3]),
        .display_h1(h1),
        .display_h0(h0),
        .display_m1(m1),
        .display_m0(m0),
        .display_s1(s1),
        .display_s0(s0),
        .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic logic [31:0] disp();
        return {8'h00, h1, h0, m1, m0, s1, s0};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press effect lands on the 6th edge; the task returns 6 edges later.
    task automatic press(input logic [3:0] mask);
        btn = mask;
        step(6);
        btn = '0;
        step(6);
    endtask

    task automatic press_n(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    task automatic do_reset();
        btn   = '0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        btn      = '0;
        rst_n    = 1'b1;
        #2;
        do_reset();

        check("rst_disp", disp(), 32'h000000);
        check("rst_alarm", {31'd0, alarm}, 32'd0);
        step(599);
        check("run_599", disp(), 32'h000059);
        step(1);
        check("run_600", disp(), 32'h000100);
        check("run_alarm", {31'd0, alarm}, 32'd0);

        pulse_cnt = 0;
        pulse_idx = 0;
        btn = B_UP;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (dut.u_db_up.o_press) begin
                pulse_cnt++;
                pulse_idx = k;
            end
        end
        btn = '0;
        step(8);
        check("held_pulse_cnt", pulse_cnt, 32'd1);
        check("held_pulse_edge", pulse_idx, 32'd5);
        pulse_cnt = 0;
        btn = B_UP;
        step(1);
        btn = '0;
        for (int k = 1; k <= 10; k++) begin
            if (dut.u_db_up.o_press) pulse_cnt++;
            step(1);
        end
        check("glitch_pulse_cnt", pulse_cnt, 32'd0);

        // Clock edit: hour 00 -> 23, minute 00 -> 01.
        do_reset();
        press(B_SC);
        press(B_DN);
        check("edit_hour_dec_wrap", disp(), 32'h230000);
        press(B_SC);
        press_n(B_UP, 61);
        check("edit_min_up61", disp(), 32'h230100);
        press(B_UP | B_DN);
        check("edit_up_dn_same", disp(), 32'h230100);
        step(30);
        check("edit_frozen", disp(), 32'h230100);
        press(B_SC);
        step(3);
        check("leave_clk_pre_tick", disp(), 32'h230100);
        step(1);
        check("leave_clk_tick", disp(), 32'h230101);

        // Alarm set to 07:30, time keeps running meanwhile.
        do_reset();
        press(B_SA);
        press_n(B_UP, 7);
        check("alm_hour_disp", disp(), 32'h070000);
        press(B_SA);
        press_n(B_UP, 30);
        check("alm_min_disp", disp(), 32'h073000);
        press(B_SA);
        press(B_SC);
        check("time_ran_in_alm", disp(), 32'h000048);
        press_n(B_UP, 7);
        press(B_SC);
        press_n(B_UP, 29);
        check("time_set_0729", disp(), 32'h072948);
        press(B_SC);
        step(584);
        check("pre_trig_disp", disp(), 32'h072959);
        check("pre_trig_alarm", {31'd0, alarm}, 32'd0);
        step(10);
        check("trig_disp", disp(), 32'h073000);
        check("trig_alarm", {31'd0, alarm}, 32'd1);
        step(29);
        check("alarm_last_cycle", {31'd0, alarm}, 32'd1);
        step(1);
        check("alarm_expired", {31'd0, alarm}, 32'd0);

        // Re-trigger, then dismiss with btn_down.
        press(B_SC);
        press(B_SC);
        press(B_DN);
        press(B_SC);
        step(594);
        check("retrig_alarm", {31'd0, alarm}, 32'd1);
        step(10);
        btn = B_DN;
        step(5);
        check("dismiss_pre", {31'd0, alarm}, 32'd1);
        step(1);
        check("dismiss_alarm", {31'd0, alarm}, 32'd0);
        check("dismiss_time", disp(), 32'h073001);
        btn = '0;
        step(4);
        check("dismiss_still_run", disp(), 32'h073002);
        check("dismiss_no_retrig", {31'd0, alarm}, 32'd0);

        // Reset mid alarm-minute edit.
        press(B_SA);
        press(B_SA);
        btn = B_UP;
        step(2);
        rst_n = 1'b0;
        #1;
        check("async_rst_disp", disp(), 32'h000000);
        check("async_rst_alarm", {31'd0, alarm}, 32'd0);
        step(1);
        check("rst_state", 32'(dut.state_q), 32'(ST_RUN));
        check("rst_armed", {31'd0, dut.armed_q}, 32'd0);
        check("rst_disp2", disp(), 32'h000000);
        btn = '0;
        step(1);
        rst_n = 1'b1;
        press(B_SC);
        press(B_DN);
        press(B_SC);
        press(B_DN);
        check("wrap_set", disp(), 32'h235900);
        press(B_SC);
        step(584);
        check("wrap_pre", disp(), 32'h235959);
        step(10);
        check("wrap_midnight", disp(), 32'h000000);
        check("disarmed_no_alarm", {31'd0, alarm}, 32'd0);
        step(1);
        check("disarmed_no_alarm2", {31'd0, alarm}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
